// File: rtl/fp_alu_sched_pkg.sv
// Shared types for the fixed-point ALU scheduler: opcodes, FSM states and Q-format split.
package fp_alu_pkg;
  localparam int FRAC_BITS = 16;

  typedef enum logic [1:0] {
    ADD = 2'b00,
    SUB = 2'b01,
    MUL = 2'b10,
    DIV = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_t;
endpackage

// File: rtl/fp_alu_sched_alu.sv
// Combinational Q(N/2).(N/2) ALU; DIV is sign-magnitude and meant to be timed as multicycle.
// FP_ALU_SCHED_DIVZERO_EN adds divide-by-zero saturation and a flag output.
module fp_alu
  import fp_alu_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  op_t          op,
  output logic [N-1:0] result
`ifdef FP_ALU_SCHED_DIVZERO_EN
  ,
  output logic         div_zero
`endif
);
  localparam int FRAC = N / 2;
  localparam int DW = N - 1 + FRAC;

  logic         sign;
  logic [N-1:0] mag_a, mag_b, mul_mag;
  logic [N-2:0] div_mag;

  // Operation select; MUL works on two's complement magnitudes, DIV on raw sign-magnitude
  always_comb begin
    sign    = a[N-1] ^ b[N-1];
    mag_a   = a[N-1] ? (~a + 1'b1) : a;
    mag_b   = b[N-1] ? (~b + 1'b1) : b;
    mul_mag = N'(((2 * N)'(mag_a) * (2 * N)'(mag_b)) >> FRAC);
    div_mag = (N - 1)'((DW'(a[N-2:0]) << FRAC) / DW'(b[N-2:0]));
`ifdef FP_ALU_SCHED_DIVZERO_EN
    div_zero = (op == DIV) && (b[N-2:0] == '0);
`endif
    case (op)
      ADD:     result = a + b;
      SUB:     result = a - b;
      MUL:     result = sign ? (~mul_mag + 1'b1) : mul_mag;
      DIV:     result = {sign, div_mag};
      default: result = '0;
    endcase
`ifdef FP_ALU_SCHED_DIVZERO_EN
    if (div_zero) begin
      result = {sign, {(N - 1){1'b1}}};
    end else begin
      result = result;
    end
`endif
  end
endmodule

// File: rtl/fp_alu_sched_rr_arbiter.sv
// Round-robin arbiter: first request at or after the pointer (circular) wins.
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx,
  output logic                       any
);
  localparam int IW = $clog2(NUM_REQ);

  // Circular priority scan starting at the pointer
  always_comb begin
    int j;
    j = 0;
    grant = '0;
    grant_idx = '0;
    any = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = (int'(ptr) + i) % NUM_REQ;
      if (!any && req[j]) begin
        any = 1'b1;
        grant[j] = 1'b1;
        grant_idx = IW'(j);
      end else begin
        any = any;
      end
    end
  end
endmodule

// File: rtl/fp_alu_sched.sv
// Round-robin scheduler sharing one fixed-point ALU among NUM_REQ requesters.
// Optional FP_ALU_SCHED_DIVZERO_EN: saturating divide-by-zero with resp_err output.
module fp_alu_sched
  import fp_alu_pkg::*;
#(
  parameter int N          = 32,
  parameter int NUM_REQ    = 4,
  parameter int DIV_CYCLES = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ-1:0][N-1:0]     req_a,
  input  logic [NUM_REQ-1:0][N-1:0]     req_b,
  input  logic [NUM_REQ-1:0][1:0]       req_op,
  output logic [NUM_REQ-1:0]            resp_valid,
  input  logic [NUM_REQ-1:0]            resp_ready,
  output logic [N-1:0]                  resp_result,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy
`ifdef FP_ALU_SCHED_DIVZERO_EN
  ,
  output logic                          resp_err
`endif
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;

  state_t          state, state_next;
  logic [IW-1:0]   ptr, win_idx;
  logic [NUM_REQ-1:0] win;
  logic            win_any, accept, finish, release_resp;
  logic [CW-1:0]   cnt;
  logic [N-1:0]    a_q, b_q, alu_out;
  op_t             op_q;
`ifdef FP_ALU_SCHED_DIVZERO_EN
  logic            alu_div_zero;
`endif

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req       (req_valid),
    .ptr       (ptr),
    .grant     (win),
    .grant_idx (win_idx),
    .any       (win_any)
  );

  // ALU only ever sees the latched operands so its inputs stay stable through EXEC
  fp_alu #(.N(N)) u_alu (
    .a        (a_q),
    .b        (b_q),
    .op       (op_q),
    .result   (alu_out)
`ifdef FP_ALU_SCHED_DIVZERO_EN
    ,
    .div_zero (alu_div_zero)
`endif
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state and handshake decode
  always_comb begin
    state_next   = state;
    req_ready    = '0;
    accept       = 1'b0;
    finish       = 1'b0;
    release_resp = 1'b0;
    case (state)
      IDLE: begin
        req_ready = rst ? '0 : win;
        accept    = win_any;
        if (accept) state_next = EXEC;
        else        state_next = IDLE;
      end
      EXEC: begin
        if (cnt == '0) begin
          finish     = 1'b1;
          state_next = RESP;
        end else begin
          state_next = EXEC;
        end
      end
      RESP: begin
        if (resp_ready[grant_id]) begin
          release_resp = 1'b1;
          state_next   = IDLE;
        end else begin
          state_next = RESP;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand capture, execute countdown and registered response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr         <= '0;
      cnt         <= '0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= ADD;
      grant_id    <= '0;
      resp_valid  <= '0;
      resp_result <= '0;
      busy        <= 1'b0;
`ifdef FP_ALU_SCHED_DIVZERO_EN
      resp_err    <= 1'b0;
`endif
    end else begin
      busy <= (state_next != IDLE);
      if (accept) begin
        a_q      <= req_a[win_idx];
        b_q      <= req_b[win_idx];
        op_q     <= op_t'(req_op[win_idx]);
        grant_id <= win_idx;
        ptr      <= (win_idx == IW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
        cnt      <= (op_t'(req_op[win_idx]) == DIV) ? CW'(DIV_CYCLES - 1) : '0;
      end else if (state == EXEC && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end else begin
        cnt <= cnt;
      end
      if (finish) begin
        resp_result <= alu_out;
        resp_valid  <= {{(NUM_REQ - 1){1'b0}}, 1'b1} << grant_id;
`ifdef FP_ALU_SCHED_DIVZERO_EN
        resp_err    <= alu_div_zero;
`endif
      end else if (release_resp) begin
        resp_valid <= '0;
`ifdef FP_ALU_SCHED_DIVZERO_EN
        resp_err   <= 1'b0;
`endif
      end else begin
        resp_valid <= resp_valid;
      end
    end
  end
endmodule

// File: tb/tb_fp_alu_sched.sv
// Directed self-checking bench for fp_alu_sched (N=32, NUM_REQ=4, DIV_CYCLES=4).
module tb_fp_alu_sched;
  logic             clk = 1'b0;
  logic             rst;
  logic [3:0]       req_valid, req_ready, resp_valid, resp_ready;
  logic [3:0][31:0] req_a, req_b;
  logic [3:0][1:0]  req_op;
  logic [31:0]      resp_result;
  logic [1:0]       grant_id;
  logic             busy;
`ifdef FP_ALU_SCHED_DIVZERO_EN
  logic             resp_err;
`endif
  int checks = 0;
  int failures = 0;
  int cyc = 0;

  fp_alu_sched #(.N(32), .NUM_REQ(4), .DIV_CYCLES(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_op      (req_op),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_result (resp_result),
    .grant_id    (grant_id),
    .busy        (busy)
`ifdef FP_ALU_SCHED_DIVZERO_EN
    ,
    .resp_err    (resp_err)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic apply_reset();
    rst = 1'b1;
    req_valid = '0; resp_ready = '0; req_a = '0; req_b = '0; req_op = '0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
  endtask

  // Issue one op on requester r, wait for its response and acknowledge it.
  task automatic run_op(input int r, input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                        output logic [31:0] res, output int lat, output int gid, output int busy_n,
                        output logic err, output bit ok);
    int t;
    ok = 1'b1; lat = 0; busy_n = 0; res = '0; gid = -1; err = 1'b0;
    @(negedge clk);
    req_a[r] = a; req_b[r] = b; req_op[r] = op; req_valid[r] = 1'b1;
    #1;
    t = 0;
    while (req_ready[r] !== 1'b1 && t < 50) begin @(negedge clk); #1; t++; end
    if (req_ready[r] !== 1'b1) begin ok = 1'b0; req_valid[r] = 1'b0; return; end
    @(posedge clk); #1;
    req_valid[r] = 1'b0;
    do begin
      @(negedge clk);
      lat++;
      if (busy === 1'b1) busy_n++;
    end while (resp_valid[r] !== 1'b1 && lat < 50);
    if (resp_valid[r] !== 1'b1) begin ok = 1'b0; return; end
    res = resp_result;
    gid = int'(grant_id);
`ifdef FP_ALU_SCHED_DIVZERO_EN
    err = resp_err;
`endif
    resp_ready[r] = 1'b1;
    @(posedge clk); #1;
    resp_ready[r] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 4'hF; resp_ready = '0; req_a = '0; req_b = '0; req_op = '0;
    #1;
    checks++; if (req_ready !== 4'h0) begin failures++; $display("FAIL reset_req_ready got=%b exp=0000", req_ready); end
    checks++; if (resp_valid !== 4'h0) begin failures++; $display("FAIL reset_resp_valid got=%b exp=0000", resp_valid); end
    checks++; if (resp_result !== 32'h0) begin failures++; $display("FAIL reset_resp_result got=%h exp=0", resp_result); end
    checks++; if (grant_id !== 2'd0) begin failures++; $display("FAIL reset_grant_id got=%0d exp=0", grant_id); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
`ifdef FP_ALU_SCHED_DIVZERO_EN
    checks++; if (resp_err !== 1'b0) begin failures++; $display("FAIL reset_resp_err got=%b exp=0", resp_err); end
`endif
    apply_reset();
  endtask

  task automatic test_add();
    logic [31:0] res; int lat, gid, bn; logic err; bit ok;
    run_op(0, 32'h0001_0000, 32'h0002_0000, 2'b00, res, lat, gid, bn, err, ok);
    checks++; if (!ok) begin failures++; $display("FAIL add_timeout got=timeout exp=response"); end
    checks++; if (res !== 32'h0003_0000) begin failures++; $display("FAIL add_result got=%h exp=00030000", res); end
    checks++; if (lat !== 2) begin failures++; $display("FAIL add_latency got=%0d exp=2", lat); end
    checks++; if (gid !== 0) begin failures++; $display("FAIL add_grant_id got=%0d exp=0", gid); end
  endtask

  task automatic test_mul();
    logic [31:0] res; int lat, gid, bn; logic err; bit ok;
    run_op(1, 32'hFFFE_8000, 32'h0002_0000, 2'b10, res, lat, gid, bn, err, ok);
    checks++; if (!ok || res !== 32'hFFFD_0000) begin failures++; $display("FAIL mul_neg got=%h exp=fffd0000", res); end
    checks++; if (gid !== 1) begin failures++; $display("FAIL mul_neg_grant got=%0d exp=1", gid); end
    run_op(2, 32'h0001_8000, 32'h0002_0000, 2'b10, res, lat, gid, bn, err, ok);
    checks++; if (!ok || res !== 32'h0003_0000) begin failures++; $display("FAIL mul_pos got=%h exp=00030000", res); end
    checks++; if (lat !== 2) begin failures++; $display("FAIL mul_latency got=%0d exp=2", lat); end
  endtask

  task automatic test_sub_wrap();
    logic [31:0] res; int lat, gid, bn; logic err; bit ok;
    run_op(3, 32'h0001_0000, 32'h0003_0000, 2'b01, res, lat, gid, bn, err, ok);
    checks++; if (!ok || res !== 32'hFFFE_0000) begin failures++; $display("FAIL sub_neg got=%h exp=fffe0000", res); end
    run_op(0, 32'h7FFF_FFFF, 32'h0000_0001, 2'b00, res, lat, gid, bn, err, ok);
    checks++; if (!ok || res !== 32'h8000_0000) begin failures++; $display("FAIL add_wrap got=%h exp=80000000", res); end
  endtask

  task automatic test_div();
    logic [31:0] res; int lat, gid, bn; logic err; bit ok;
    run_op(1, 32'h0003_0000, 32'h0002_0000, 2'b11, res, lat, gid, bn, err, ok);
    checks++; if (!ok || res !== 32'h0001_8000) begin failures++; $display("FAIL div_result got=%h exp=00018000", res); end
    checks++; if (lat !== 5) begin failures++; $display("FAIL div_latency got=%0d exp=5", lat); end
    checks++; if (bn !== 5) begin failures++; $display("FAIL div_busy_cycles got=%0d exp=5", bn); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL div_busy_after got=%b exp=0", busy); end
    run_op(2, 32'h8003_0000, 32'h0002_0000, 2'b11, res, lat, gid, bn, err, ok);
    checks++; if (!ok || res !== 32'h8001_8000) begin failures++; $display("FAIL div_neg got=%h exp=80018000", res); end
  endtask

  task automatic test_back_to_back();
    int t0 = -1;
    int t1 = -1;
    @(negedge clk);
    req_a[0] = 32'h0001_0000; req_b[0] = 32'h0001_0000; req_op[0] = 2'b00;
    req_a[1] = 32'h0002_0000; req_b[1] = 32'h0001_0000; req_op[1] = 2'b00;
    req_valid[1:0] = 2'b11; resp_ready = 4'b0011;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (req_ready[0] === 1'b1) t0 = cyc;
      if (req_ready[1] === 1'b1) t1 = cyc;
      @(posedge clk); #1;
      if (t0 >= 0) req_valid[0] = 1'b0;
      if (t1 >= 0) req_valid[1] = 1'b0;
      @(negedge clk);
    end
    resp_ready = '0;
    checks++; if (t0 < 0 || t1 < 0) begin failures++; $display("FAIL b2b_accepts got=t0:%0d,t1:%0d exp=both", t0, t1); end
    checks++; if ((t1 - t0 !== 3) && (t0 - t1 !== 3)) begin failures++; $display("FAIL b2b_interval got=%0d exp=3", t1 - t0); end
  endtask

  task automatic test_round_robin();
    int exp_order[5] = '{0, 1, 2, 3, 0};
    int g, t, ones;
    logic [31:0] held;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      req_a[i] = 32'(i) << 16; req_b[i] = 32'h0001_0000; req_op[i] = 2'b00;
    end
    req_valid = 4'hF;
    for (int k = 0; k < 5; k++) begin
      #1;
      t = 0;
      while (req_ready === 4'h0 && t < 20) begin @(negedge clk); #1; t++; end
      ones = 0; g = -1;
      for (int i = 0; i < 4; i++) if (req_ready[i] === 1'b1) begin ones++; g = i; end
      checks++; if (ones !== 1) begin failures++; $display("FAIL rr_onehot got=%b exp=one_bit", req_ready); end
      checks++; if (g !== exp_order[k]) begin failures++; $display("FAIL rr_order got=%0d exp=%0d", g, exp_order[k]); end
      if (g < 0) g = 0;
      @(posedge clk); #1;
      t = 0;
      do begin @(negedge clk); t++; end while (resp_valid[g] !== 1'b1 && t < 20);
      checks++; if (resp_valid !== (4'b0001 << g)) begin failures++; $display("FAIL rr_resp_valid got=%b exp=%b", resp_valid, 4'b0001 << g); end
      checks++; if (resp_result !== (32'(g + 1) << 16)) begin failures++; $display("FAIL rr_result got=%h exp=%h", resp_result, 32'(g + 1) << 16); end
      if (k == 0) begin
        held = resp_result;
        resp_ready = ~(4'b0001 << g);
        for (int h = 0; h < 5; h++) begin
          @(negedge clk);
          checks++; if (resp_result !== held || resp_valid !== (4'b0001 << g)) begin
            failures++; $display("FAIL rr_hold got=%h/%b exp=%h/%b", resp_result, resp_valid, held, 4'b0001 << g); end
          checks++; if (req_ready !== 4'h0) begin failures++; $display("FAIL rr_hold_no_accept got=%b exp=0000", req_ready); end
        end
      end
      resp_ready = 4'b0001 << g;
      @(posedge clk); #1;
      resp_ready = '0;
      @(negedge clk);
    end
    req_valid = '0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int t;
    apply_reset();
    @(negedge clk);
    req_a[2] = 32'h0003_0000; req_b[2] = 32'h0002_0000; req_op[2] = 2'b11; req_valid[2] = 1'b1;
    #1;
    t = 0;
    while (req_ready[2] !== 1'b1 && t < 20) begin @(negedge clk); #1; t++; end
    @(posedge clk); #1;
    req_a[1] = 32'h0001_0000; req_b[1] = 32'h0002_0000; req_op[1] = 2'b00; req_valid[1] = 1'b1;
    req_a[3] = 32'h0005_0000; req_b[3] = 32'h0001_0000; req_op[3] = 2'b00; req_valid[3] = 1'b1;
    @(negedge clk); #2;
    checks++; if (busy !== 1'b1 || grant_id !== 2'd2) begin failures++; $display("FAIL mid_exec got=busy%b,id%0d exp=busy1,id2", busy, grant_id); end
    rst = 1'b1;
    #1;
    checks++; if (resp_valid !== 4'h0 || busy !== 1'b0 || req_ready !== 4'h0) begin
      failures++; $display("FAIL mid_reset_outs got=%b/%b/%b exp=0000/0/0000", resp_valid, busy, req_ready); end
    checks++; if (grant_id !== 2'd0 || resp_result !== 32'h0) begin
      failures++; $display("FAIL mid_reset_regs got=%0d/%h exp=0/0", grant_id, resp_result); end
    req_valid[2] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL mid_regrant got=%b exp=0010", req_ready); end
    @(posedge clk); #1;
    req_valid[1] = 1'b0; req_valid[3] = 1'b0;
    t = 0;
    do begin @(negedge clk); t++; end while (resp_valid === 4'h0 && t < 20);
    checks++; if (resp_valid !== 4'b0010 || grant_id !== 2'd1) begin
      failures++; $display("FAIL mid_resp got=%b/%0d exp=0010/1", resp_valid, grant_id); end
    checks++; if (resp_result !== 32'h0003_0000) begin failures++; $display("FAIL mid_result got=%h exp=00030000", resp_result); end
    resp_ready[1] = 1'b1;
    @(posedge clk); #1;
    resp_ready[1] = 1'b0;
  endtask

`ifdef FP_ALU_SCHED_DIVZERO_EN
  task automatic test_divzero();
    logic [31:0] res; int lat, gid, bn; logic err; bit ok;
    run_op(0, 32'h0001_0000, 32'h0000_0000, 2'b11, res, lat, gid, bn, err, ok);
    checks++; if (!ok || res !== 32'h7FFF_FFFF) begin failures++; $display("FAIL divzero_result got=%h exp=7fffffff", res); end
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL divzero_err got=%b exp=1", err); end
    checks++; if (lat !== 5) begin failures++; $display("FAIL divzero_latency got=%0d exp=5", lat); end
    checks++; if (resp_err !== 1'b0) begin failures++; $display("FAIL divzero_err_clear got=%b exp=0", resp_err); end
    run_op(1, 32'h0001_0000, 32'h0001_0000, 2'b00, res, lat, gid, bn, err, ok);
    checks++; if (!ok || res !== 32'h0002_0000 || err !== 1'b0) begin
      failures++; $display("FAIL divzero_next_add got=%h/%b exp=00020000/0", res, err); end
  endtask
`endif

  initial begin
    test_reset();
    test_add();
    test_mul();
    test_sub_wrap();
    test_div();
    test_back_to_back();
    test_round_robin();
    test_reset_mid();
`ifdef FP_ALU_SCHED_DIVZERO_EN
    test_divzero();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
